// File: rtl/servo_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : servo_sweep_ctrl                                            |
// | Description : Angle sequencer for the echo-scan servo. Sweeps the angle   |
// |               between MIN_ANGLE and MAX_ANGLE in STEP increments; at each |
// |               point waits SETTLE_MS, issues one measurement request and   |
// |               waits for its completion before stepping.                  |
// |               Optional measurement timeout: define SWEEP_TIMEOUT_EN.      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module servo_sweep_ctrl #(
   parameter int FREQ       = 50_000_000,
   parameter int MIN_ANGLE  = 0,
   parameter int MAX_ANGLE  = 255,
   parameter int STEP       = 5,
   parameter int SETTLE_MS  = 40,
   parameter int TIMEOUT_MS = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       meas_done,
   output logic [7:0] angle,
   output logic       dir,
   output logic       meas_req,
   output logic       sweep_end,
   output logic       meas_timeout
);

   // Cycle counts; the counter is loaded with count-1 so that exactly
   // count cycles are spent in the timed state.
   localparam logic [31:0] c_SETTLE_CYC  = 32'(FREQ / 1000 * SETTLE_MS);
   localparam logic [31:0] c_SETTLE_LOAD = c_SETTLE_CYC - 32'd1;
   localparam logic [31:0] c_TIMEOUT_CYC = 32'(FREQ / 1000 * TIMEOUT_MS);

   // Step arithmetic is carried out in 9 bits so angle+STEP cannot wrap.
   localparam logic [8:0] c_MIN9  = 9'(MIN_ANGLE);
   localparam logic [8:0] c_MAX9  = 9'(MAX_ANGLE);
   localparam logic [8:0] c_STEP9 = 9'(STEP);
   localparam logic [7:0] c_MIN8  = 8'(MIN_ANGLE);
   localparam logic [7:0] c_MAX8  = 8'(MAX_ANGLE);
   localparam logic [7:0] c_STEP8 = 8'(STEP);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_STEP    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_cnt;
   logic [7:0]  r_angle;
   logic        r_dir;
   logic        r_meas_req;
   logic        r_sweep_end;

   logic        w_cnt_zero;
   logic        w_enter_meas;
   logic [8:0]  w_up_sum;
   logic        w_hit_max;
   logic        w_hit_min;

   assign w_cnt_zero   = (r_cnt == 32'd0);
   assign w_enter_meas = (r_state == S_SETTLE) && (w_next == S_MEASURE);
   assign w_up_sum     = {1'b0, r_angle} + c_STEP9;
   assign w_hit_max    = (w_up_sum >= c_MAX9);
   assign w_hit_min    = ({1'b0, r_angle} <= (c_MIN9 + c_STEP9));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; enable is only looked at in IDLE and STEP
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (enable) w_next = S_SETTLE;
         S_SETTLE:  if (w_cnt_zero) w_next = S_MEASURE;
         S_MEASURE: begin
            if (meas_done) begin
               w_next = S_STEP;
            end
`ifdef SWEEP_TIMEOUT_EN
            else if (w_cnt_zero) begin
               w_next = S_STEP;
            end
`endif
         end
         S_STEP:    w_next = enable ? S_SETTLE : S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Shared down-counter: settle time, and measurement timeout when built
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 32'd0;
      end else if ((r_state != S_SETTLE) && (w_next == S_SETTLE)) begin
         r_cnt <= c_SETTLE_LOAD;
      end
`ifdef SWEEP_TIMEOUT_EN
      else if (w_enter_meas) begin
         r_cnt <= c_TIMEOUT_CYC - 32'd1;
      end
`endif
      else if (!w_cnt_zero) begin
         r_cnt <= r_cnt - 32'd1;
      end
   end

   // Angle/direction stepping and the single-cycle request/end pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_angle     <= c_MIN8;
         r_dir       <= 1'b1;
         r_meas_req  <= 1'b0;
         r_sweep_end <= 1'b0;
      end else begin
         r_meas_req  <= w_enter_meas;
         r_sweep_end <= 1'b0;
         if (r_state == S_STEP) begin
            if (r_dir) begin
               if (w_hit_max) begin
                  r_angle     <= c_MAX8;
                  r_dir       <= 1'b0;
                  r_sweep_end <= 1'b1;
               end else begin
                  r_angle <= w_up_sum[7:0];
               end
            end else begin
               if (w_hit_min) begin
                  r_angle     <= c_MIN8;
                  r_dir       <= 1'b1;
                  r_sweep_end <= 1'b1;
               end else begin
                  r_angle <= r_angle - c_STEP8;
               end
            end
         end
      end
   end

`ifdef SWEEP_TIMEOUT_EN
   logic r_meas_timeout;

   // Sticky timeout flag: set on expiry without meas_done, cleared with the next request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meas_timeout <= 1'b0;
      end else if (w_enter_meas) begin
         r_meas_timeout <= 1'b0;
      end else if ((r_state == S_MEASURE) && w_cnt_zero && !meas_done) begin
         r_meas_timeout <= 1'b1;
      end
   end

   assign meas_timeout = r_meas_timeout;
`else
   // Timeout length is meaningless without the timeout logic.
   logic w_unused_cfg;
   assign w_unused_cfg = (c_TIMEOUT_CYC == 32'd0);
   assign meas_timeout = 1'b0;
`endif

   assign angle     = r_angle;
   assign dir       = r_dir;
   assign meas_req  = r_meas_req;
   assign sweep_end = r_sweep_end;

endmodule
`default_nettype wire

// File: tb/tb_servo_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_servo_sweep_ctrl                                         |
// | Description : Self-checking bench for servo_sweep_ctrl. Expected request  |
// |               angles and sweep end points are queued and compared as the  |
// |               DUT emits meas_req / sweep_end. Build with SWEEP_TIMEOUT_EN |
// |               to exercise the timeout path.                               |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_servo_sweep_ctrl;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       meas_done;
   logic [7:0] angle;
   logic       dir;
   logic       meas_req;
   logic       sweep_end;
   logic       meas_timeout;

   servo_sweep_ctrl #(
      .FREQ      (1000),
      .MIN_ANGLE (0),
      .MAX_ANGLE (255),
      .STEP      (100),
      .SETTLE_MS (3),
      .TIMEOUT_MS(5)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .meas_done   (meas_done),
      .angle       (angle),
      .dir         (dir),
      .meas_req    (meas_req),
      .sweep_end   (sweep_end),
      .meas_timeout(meas_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per expected measurement: echo answer delay (-1 = never)
   // and the angle/direction the request must be issued at.
   typedef struct {
      int delay;
      int exp_angle;
      int exp_dir;
   } vec_t;

   typedef struct {
      int exp_angle;
      int exp_dir;
   } se_t;

   vec_t exp_q[$];
   se_t  se_q[$];
   vec_t tbl[8];

   int compared   = 0;
   int mismatched = 0;
   int cd         = -1;
   bit inj        = 1'b0;
   bit saw_req    = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one cycle: sample on the falling edge, score requests and
   // sweep ends, and drive the echo model's meas_done.
   task automatic tick();
      vec_t v;
      se_t  s;
      bit   md;
      @(negedge clk);
      saw_req = meas_req;
      if (cd > 0) cd--;
      if (meas_req) begin
         chk("timeout_clear_on_req", meas_timeout, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_req_angle", angle, -1);
         end else begin
            v = exp_q.pop_front();
            chk("req_angle", angle, v.exp_angle);
            chk("req_dir", dir, v.exp_dir);
            cd = v.delay;
         end
      end
      if (sweep_end) begin
         if (se_q.size() == 0) begin
            chk("unexpected_sweep_end_angle", angle, -1);
         end else begin
            s = se_q.pop_front();
            chk("sweep_end_angle", angle, s.exp_angle);
            chk("sweep_end_dir", dir, s.exp_dir);
         end
      end
      md = 1'b0;
      if (cd == 0) begin
         md = 1'b1;
         cd = -1;
      end
      if (inj) begin
         md  = 1'b1;
         inj = 1'b0;
      end
      meas_done = md;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Tick until a meas_req is seen; optionally inject a stray meas_done.
   task automatic wait_req(input int inj_at, output int n);
      n = 0;
      do begin
         tick();
         n++;
         if (n == inj_at) inj = 1'b1;
      end while (!saw_req && n < 40);
   endtask

   task automatic drain_q(input string name);
      int g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         tick();
         g++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic wait_angle(input int target);
      int g = 0;
      while (angle != 8'(target) && g < 200) begin
         tick();
         g++;
      end
      chk("wait_angle", angle, target);
   endtask

   initial begin
      int n;

      tbl[0] = '{2, 0,   1};
      tbl[1] = '{2, 100, 1};
      tbl[2] = '{1, 200, 1};
      tbl[3] = '{0, 255, 0};
      tbl[4] = '{2, 155, 0};
      tbl[5] = '{2, 55,  0};
      tbl[6] = '{2, 0,   1};
      tbl[7] = '{2, 100, 1};

      rst_n     = 1'b0;
      enable    = 1'b0;
      meas_done = 1'b0;
      ticks(3);
      chk("rst_angle", angle, 0);
      chk("rst_dir", dir, 1);
      chk("rst_meas_req", meas_req, 0);
      chk("rst_sweep_end", sweep_end, 0);
      chk("rst_meas_timeout", meas_timeout, 0);
      rst_n = 1'b1;
      ticks(2);
      chk("idle_angle_held", angle, 0);

      // Full sweep sequence from the table
      for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i]);
      se_q.push_back('{255, 0});
      se_q.push_back('{0, 1});
      enable = 1'b1;
      wait_req(0, n);
      chk("first_req_latency", n, 4);
      drain_q("sweep_reqs_done");
      enable = 1'b0;
      ticks(30);
      chk("sweep_park_angle", angle, 200);
      chk("sweep_park_dir", dir, 1);
      chk("sweep_ends_seen", se_q.size(), 0);

      // Drop enable while settling at 100
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.push_back('{2, 0, 1});
      enable = 1'b1;
      wait_angle(100);
      enable = 1'b0;
      exp_q.push_back('{2, 100, 1});
      ticks(40);
      chk("park_angle", angle, 200);
      chk("park_dir", dir, 1);
      chk("park_reqs_done", exp_q.size(), 0);

      // Stray meas_done in IDLE
      inj = 1'b1;
      ticks(10);
      chk("idle_done_ignored", angle, 200);

      // Resume; stray meas_done during SETTLE must not shorten the settle
      exp_q.push_back('{2, 200, 1});
      se_q.push_back('{255, 0});
      enable = 1'b1;
      wait_req(1, n);
      chk("resume_req_latency", n, 4);

      // Reset while measuring at 155
      exp_q.push_back('{2, 255, 0});
      exp_q.push_back('{-1, 155, 0});
      drain_q("pre_reset_reqs");
      tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst_angle", angle, 0);
      chk("async_rst_dir", dir, 1);
      chk("async_rst_meas_req", meas_req, 0);
      chk("async_rst_sweep_end", sweep_end, 0);
      chk("async_rst_timeout", meas_timeout, 0);
      chk("pre_reset_sweep_ends", se_q.size(), 0);
      cd = -1;
      ticks(2);
      rst_n = 1'b1;
      exp_q.push_back('{2, 0, 1});
      wait_req(0, n);
      chk("restart_req_latency", n, 4);

      // Unanswered measurement at 100
      exp_q.push_back('{-1, 100, 1});
      drain_q("unanswered_req");
`ifdef SWEEP_TIMEOUT_EN
      n = 0;
      do begin
         tick();
         n++;
      end while (!meas_timeout && n < 20);
      chk("timeout_delay", n, 5);
      tick();
      chk("timeout_advance_angle", angle, 200);
      chk("timeout_sticky", meas_timeout, 1);
      se_q.push_back('{255, 0});
      exp_q.push_back('{4, 200, 1});
      drain_q("answer_on_last_cycle_req");
      enable = 1'b0;
      ticks(8);
      chk("no_timeout_on_last_cycle", meas_timeout, 0);
      chk("last_cycle_answer_angle", angle, 255);
      chk("last_cycle_answer_dir", dir, 0);
`else
      enable = 1'b0;
      ticks(20);
      chk("wait_forever_angle", angle, 100);
      chk("timeout_tied_low", meas_timeout, 0);
      inj = 1'b1;
      ticks(4);
      chk("late_answer_angle", angle, 200);
`endif
      ticks(20);
      chk("final_reqs_done", exp_q.size(), 0);
      chk("final_sweep_ends_done", se_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
